// File: rtl/mdc_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdc_stream_pkg
// Brief    : Shared types and default widths for the MDC output stream drain.
// Revision : 1.0 - initial release
// ============================================================================
package mdc_stream_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/mdc_slack_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mdc_slack_fifo
// Brief    : Registered-storage FIFO with occupancy-based almost-full at
//            free entries <= SLACK.
// Revision : 1.0 - initial release
// ============================================================================
module mdc_slack_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int SLACK  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_valid,
    output logic              o_full,
    output logic              o_almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] c_depth   = CW'(DEPTH);
    localparam logic [CW-1:0] c_af_lvl  = CW'(DEPTH - SLACK);
    localparam logic [CW-1:0] c_cnt_one = CW'(1);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    // Storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata       = r_mem[r_rptr];
    assign o_valid       = (r_count != '0);
    assign o_full        = (r_count == c_depth);
    assign o_almost_full = (r_count >= c_af_lvl);

endmodule
`default_nettype wire

// File: rtl/mdc_stream_drain.sv
`default_nettype none
// ============================================================================
// Module   : mdc_stream_drain
// Brief    : Drains the MDC output stream (data/wr/full) into a valid/ready
//            sink, counts a job length and pulses done. Optional out_last
//            output enabled by defining MDC_DRAIN_TLAST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mdc_stream_drain
    import mdc_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 8,
    parameter int SLACK  = 2,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_wr,
    output logic              o_in_full,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    input  logic [LEN_W-1:0]  i_cfg_len,
    input  logic              i_start,
`ifdef MDC_DRAIN_TLAST_EN
    output logic              o_out_last,
`endif
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow
);

    localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);

    drain_state_t     r_state;
    drain_state_t     w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_acc_cnt;
    logic [LEN_W-1:0] r_pop_cnt;
    logic             r_overflow;
    logic             r_zero_done;

    logic             w_run;
    logic             w_start_ok;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_acc_sat;
    logic             w_head_last;
    logic             w_fifo_valid;
    logic             w_fifo_full;
    logic             w_fifo_af;

    assign w_run      = (r_state == RUN);
    assign w_start_ok = i_start && (r_state == IDLE);
    assign w_acc_sat  = (r_acc_cnt == r_len);
    assign w_pop      = w_fifo_valid && i_out_ready;
    // A full buffer still takes a word when the head leaves in the same cycle.
    assign w_push     = i_in_wr && w_run && (!w_fifo_full || w_pop) && !w_acc_sat;
    assign w_drop     = i_in_wr && !w_push;
    // Head-of-buffer word is the final word of the job.
    assign w_head_last = w_run && w_fifo_valid && ((r_pop_cnt + c_len_one) == r_len);

    mdc_slack_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .SLACK  (SLACK)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_push        (w_push),
        .i_wdata       (i_in_data),
        .i_pop         (w_pop),
        .o_rdata       (o_out_data),
        .o_valid       (w_fifo_valid),
        .o_full        (w_fifo_full),
        .o_almost_full (w_fifo_af)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = (r_state != IDLE);
        o_done      = (r_state == DONE) || r_zero_done;
        o_in_full   = !w_run || w_fifo_af || w_acc_sat;
        case (r_state)
            IDLE: begin
                if (w_start_ok && (i_cfg_len != '0)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_pop && w_head_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_acc_cnt   <= '0;
            r_pop_cnt   <= '0;
            r_overflow  <= 1'b0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= w_start_ok && (i_cfg_len == '0);
            if (w_start_ok) begin
                r_len     <= i_cfg_len;
                r_acc_cnt <= '0;
                r_pop_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_acc_cnt <= r_acc_cnt + c_len_one;
                end
                if (w_pop && (r_pop_cnt != r_len)) begin
                    r_pop_cnt <= r_pop_cnt + c_len_one;
                end
            end
            // A dropped word in the start cycle still marks the new job.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_start_ok) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_out_valid = w_fifo_valid;
    assign o_overflow  = r_overflow;

`ifdef MDC_DRAIN_TLAST_EN
    assign o_out_last = w_head_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mdc_stream_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdc_stream_drain
// Brief    : Directed self-checking bench for mdc_stream_drain.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdc_stream_drain;

    logic        clk;
    logic        rst_n;
    logic [31:0] r_in_data;
    logic        r_in_wr;
    logic        w_in_full;
    logic [31:0] w_out_data;
    logic        w_out_valid;
    logic        r_out_ready;
    logic [15:0] r_cfg_len;
    logic        r_start;
    logic        w_busy;
    logic        w_done;
    logic        w_overflow;
`ifdef MDC_DRAIN_TLAST_EN
    logic        w_out_last;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    mdc_stream_drain dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_data   (r_in_data),
        .i_in_wr     (r_in_wr),
        .o_in_full   (w_in_full),
        .o_out_data  (w_out_data),
        .o_out_valid (w_out_valid),
        .i_out_ready (r_out_ready),
        .i_cfg_len   (r_cfg_len),
        .i_start     (r_start),
`ifdef MDC_DRAIN_TLAST_EN
        .o_out_last  (w_out_last),
`endif
        .o_busy      (w_busy),
        .o_done      (w_done),
        .o_overflow  (w_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [31:0] word(input logic [31:0] base, input int i);
        return base + 32'(i);
    endfunction

    initial begin
        bit seen;
        rst_n = 1'b0; r_in_data = '0; r_in_wr = 1'b0; r_out_ready = 1'b0;
        r_cfg_len = '0; r_start = 1'b0;
        cyc(); cyc();
        check_eq("rst_full",     32'(w_in_full),   32'd1);
        check_eq("rst_valid",    32'(w_out_valid), 32'd0);
        check_eq("rst_busy",     32'(w_busy),      32'd0);
        check_eq("rst_done",     32'(w_done),      32'd0);
        check_eq("rst_overflow", 32'(w_overflow),  32'd0);
        rst_n = 1'b1;
        cyc();

        // len=4 streamed straight through
        r_start = 1'b1; r_cfg_len = 16'd4;
        cyc();
        r_start = 1'b0;
        check_eq("t1_busy", 32'(w_busy),    32'd1);
        check_eq("t1_full", 32'(w_in_full), 32'd0);
        r_in_wr = 1'b1; r_in_data = word(32'hA000_0000, 0); r_out_ready = 1'b1;
        cyc();
        for (int i = 1; i <= 4; i++) begin
            check_eq("t1_valid", 32'(w_out_valid), 32'd1);
            check_eq("t1_data",  w_out_data, word(32'hA000_0000, i - 1));
            if (i < 4) r_in_data = word(32'hA000_0000, i);
            else begin
                r_in_wr = 1'b0;
                check_eq("t1_full_sat", 32'(w_in_full), 32'd1);
            end
            cyc();
        end
        check_eq("t1_done",      32'(w_done),      32'd1);
        check_eq("t1_valid_end", 32'(w_out_valid), 32'd0);
        cyc();
        check_eq("t1_done_off", 32'(w_done), 32'd0);
        check_eq("t1_idle",     32'(w_busy), 32'd0);

        // len=16, sink stalled: early full at 6, two slack words land
        r_out_ready = 1'b0; r_start = 1'b1; r_cfg_len = 16'd16;
        cyc();
        r_start = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            if (k == 5) check_eq("t2_full_at5", 32'(w_in_full), 32'd0);
            if (k == 6) check_eq("t2_full_at6", 32'(w_in_full), 32'd1);
            if (k < 8) begin
                r_in_wr = 1'b1; r_in_data = word(32'hB000_0000, k);
                cyc();
            end else r_in_wr = 1'b0;
        end
        check_eq("t2_overflow", 32'(w_overflow),  32'd0);
        check_eq("t2_valid",    32'(w_out_valid), 32'd1);
        check_eq("t2_head",     w_out_data, word(32'hB000_0000, 0));
        cyc();
        check_eq("t2_hold", w_out_data, word(32'hB000_0000, 0));

        // full buffer: simultaneous push and pop
        r_in_wr = 1'b1; r_in_data = word(32'hB000_0000, 8); r_out_ready = 1'b1;
        cyc();
        r_in_wr = 1'b0;
        check_eq("t3_full",     32'(w_in_full),  32'd1);
        check_eq("t3_overflow", 32'(w_overflow), 32'd0);
        for (int j = 1; j <= 8; j++) begin
            check_eq("t3_order", w_out_data, word(32'hB000_0000, j));
            cyc();
        end
        check_eq("t3_empty", 32'(w_out_valid), 32'd0);
        for (int c = 0; c < 7; c++) begin
            r_in_wr = 1'b1; r_in_data = word(32'hC000_0000, c);
            cyc();
        end
        r_in_wr = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (w_done) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        check_eq("t3_done_seen", 32'(seen),       32'd1);
        check_eq("t3_no_ovf",    32'(w_overflow), 32'd0);
        cyc();
        check_eq("t3_idle", 32'(w_busy), 32'd0);

        // len=3 with 5 writes ignoring in_full
        r_out_ready = 1'b0; r_start = 1'b1; r_cfg_len = 16'd3;
        cyc();
        r_start = 1'b0;
        for (int w = 0; w < 5; w++) begin
            r_in_wr = 1'b1; r_in_data = word(32'hD000_0000, w);
            cyc();
        end
        r_in_wr = 1'b0;
        check_eq("t4_overflow", 32'(w_overflow), 32'd1);
        check_eq("t4_full",     32'(w_in_full),  32'd1);
        for (int j = 0; j < 3; j++) begin
            check_eq("t4_data", w_out_data, word(32'hD000_0000, j));
            r_out_ready = 1'b1;
            cyc();
        end
        check_eq("t4_done",     32'(w_done),      32'd1);
        check_eq("t4_empty",    32'(w_out_valid), 32'd0);
        check_eq("t4_ovf_hold", 32'(w_overflow),  32'd1);
        cyc();
        r_start = 1'b1; r_cfg_len = 16'd8; r_out_ready = 1'b0;
        cyc();
        r_start = 1'b0;
        check_eq("t4_ovf_clear", 32'(w_overflow), 32'd0);

        // reset with 5 words buffered mid-job
        for (int w = 0; w < 5; w++) begin
            r_in_wr = 1'b1; r_in_data = word(32'hE000_0000, w);
            cyc();
        end
        r_in_wr = 1'b0;
        check_eq("t5_pre_valid", 32'(w_out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_full",  32'(w_in_full),   32'd1);
        check_eq("t5_rst_valid", 32'(w_out_valid), 32'd0);
        check_eq("t5_rst_busy",  32'(w_busy),      32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        r_start = 1'b1; r_cfg_len = 16'd0;
        cyc();
        r_start = 1'b0;
        check_eq("t5_zero_done", 32'(w_done), 32'd1);
        check_eq("t5_zero_busy", 32'(w_busy), 32'd0);
        cyc();
        check_eq("t5_zero_off", 32'(w_done), 32'd0);

`ifdef MDC_DRAIN_TLAST_EN
        r_start = 1'b1; r_cfg_len = 16'd2; r_out_ready = 1'b0;
        cyc();
        r_start = 1'b0;
        for (int w = 0; w < 2; w++) begin
            r_in_wr = 1'b1; r_in_data = word(32'hF000_0000, w);
            cyc();
        end
        r_in_wr = 1'b0;
        check_eq("t6_last_first", 32'(w_out_last), 32'd0);
        r_out_ready = 1'b1;
        cyc();
        r_out_ready = 1'b0;
        check_eq("t6_data2",      w_out_data, word(32'hF000_0000, 1));
        check_eq("t6_last_second", 32'(w_out_last), 32'd1);
        cyc();
        check_eq("t6_last_held", 32'(w_out_last), 32'd1);
        r_out_ready = 1'b1;
        cyc();
        check_eq("t6_done",     32'(w_done),     32'd1);
        check_eq("t6_last_off", 32'(w_out_last), 32'd0);
        cyc();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
